clk_gen_ctrl: RTL and testbench

Run-time controller for the team's duty-cycle clock generator.
- Holds active period and high-time registers; sequences start, graceful stop and N-period bursts.
- Accepts new configuration over a valid/ready handshake and applies it only at a period boundary, so no runt or glitch pulse appears on clk_out.
- Sits between the register/config interface and any logic that needs a programmable divided clock or enable strobe.

---
 rtl/clk_gen_ctrl.sv | 173 +++++++++++++++++
 tb/tb_clk_gen_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gen_ctrl.sv
// clk_gen_ctrl: run-time controller for the duty-cycle clock generator.
// Holds the active period/high/burst settings, runs start / graceful stop /
// N-period bursts, and defers any configuration received while running to the
// next period boundary so clk_out never shows a runt or glitch pulse.
// Optional build macro: CLK_GEN_CTRL_PCT_EN (cfg_high is a duty percentage).
//
//   state | meaning
//   IDLE  | clk_out low, cnt held at 0, waiting for start
//   RUN   | generating periods; stop or end of burst leaves
//   DRAIN | finishing the current period after stop, then IDLE
module clk_gen_ctrl #(
  parameter int CW         = 8,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_high,
  input  logic [CW-1:0] cfg_burst,
  output logic          cfg_err,
  input  logic          start,
  input  logic          stop,
  output logic          clk_out,
  output logic          busy,
  output logic          period_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] period, period_n, high, high_n, burst, burst_n;
  logic [CW-1:0] burst_left, burst_left_n;
  logic [CW-1:0] sh_period, sh_period_n, sh_high, sh_high_n, sh_burst, sh_burst_n;
  logic          pending, pending_n;
  logic          accept, cfg_ok, wrap, running_n;
  logic [CW+6:0] high_req;
  logic          pct_bad;

`ifdef CLK_GEN_CTRL_PCT_EN
  localparam logic [CW+6:0] PCT_DIV = (CW+7)'(100);

  // Percent mode: turn the requested duty into a cycle count at full width
  always_comb begin
    high_req = ({7'd0, cfg_period} * {7'd0, cfg_high}) / PCT_DIV;
    pct_bad  = (cfg_high > CW'(99));
  end
`else
  // Cycle mode: the requested high time is taken as-is
  always_comb begin
    high_req = {7'd0, cfg_high};
    pct_bad  = 1'b0;
  end
`endif

  // Only one configuration may wait in the shadow at a time
  assign cfg_ready = (state == IDLE) || !pending;
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_period > CW'(1)) && (high_req != '0) &&
                     (high_req < {7'd0, cfg_period}) && !pct_bad;
  assign wrap      = (state != IDLE) && (cnt == period - 1'b1);

  // Next-state, counter and configuration update logic
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    period_n     = period;
    high_n       = high;
    burst_n      = burst;
    burst_left_n = burst_left;
    sh_period_n  = sh_period;
    sh_high_n    = sh_high;
    sh_burst_n   = sh_burst;
    pending_n    = pending;

    if (accept && cfg_ok) begin
      if (state == IDLE) begin
        period_n = cfg_period;
        high_n   = high_req[CW-1:0];
        burst_n  = cfg_burst;
      end else begin
        sh_period_n = cfg_period;
        sh_high_n   = high_req[CW-1:0];
        sh_burst_n  = cfg_burst;
        pending_n   = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start && !stop) begin
          state_n      = RUN;
          burst_left_n = burst_n;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_n = '0;
          if (burst_left != '0) begin
            burst_left_n = burst_left - 1'b1;
            if (burst_left == CW'(1)) state_n = IDLE;
          end
          // stop on the wrap cycle: the period is already complete
          if (stop) state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
          if (stop) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (wrap) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Every exit to IDLE happens at a wrap, so this also covers the commit on that transition
    if (wrap && pending_n) begin
      period_n  = sh_period_n;
      high_n    = sh_high_n;
      burst_n   = sh_burst_n;
      pending_n = 1'b0;
    end

    running_n = (state_n != IDLE);
  end

  // Register state, settings and the cnt-aligned outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      period      <= CW'(DEF_PERIOD);
      high        <= CW'(DEF_HIGH);
      burst       <= '0;
      burst_left  <= '0;
      sh_period   <= '0;
      sh_high     <= '0;
      sh_burst    <= '0;
      pending     <= 1'b0;
      clk_out     <= 1'b0;
      period_done <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      period      <= period_n;
      high        <= high_n;
      burst       <= burst_n;
      burst_left  <= burst_left_n;
      sh_period   <= sh_period_n;
      sh_high     <= sh_high_n;
      sh_burst    <= sh_burst_n;
      pending     <= pending_n;
      clk_out     <= running_n && (cnt_n < high_n);
      period_done <= running_n && (cnt_n == period_n - 1'b1);
      cfg_err     <= accept && !cfg_ok;
    end
  end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// tb_clk_gen_ctrl: directed-vector bench for clk_gen_ctrl.
module tb_clk_gen_ctrl;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_high;
  logic [CW-1:0] cfg_burst;
  logic          cfg_err;
  logic          start;
  logic          stop;
  logic          clk_out;
  logic          busy;
  logic          period_done;

  int n_cmp = 0;
  int n_bad = 0;

  clk_gen_ctrl #(.CW(CW), .DEF_PERIOD(10), .DEF_HIGH(6)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_burst(cfg_burst),
    .cfg_err(cfg_err), .start(start), .stop(stop), .clk_out(clk_out),
    .busy(busy), .period_done(period_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_period = '0; cfg_high = '0; cfg_burst = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_period = '0; cfg_high = '0; cfg_burst = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL reset_clk_out got %b want 0", clk_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (period_done !== 1'b0) begin n_bad++; $display("FAIL reset_period_done got %b want 0", period_done); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    // stop alone in IDLE is ignored
    stop = 1'b1; tick(); stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_stop_busy got %b want 0", busy); end
  endtask

  task automatic test_default_run();
    logic exp_clk, exp_pd;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_clk = ((i % 10) < 6);
      exp_pd  = ((i % 10) == 9);
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL default_clk i=%0d got %b want %b", i, clk_out, exp_clk); end
      n_cmp++; if (period_done !== exp_pd) begin n_bad++; $display("FAIL default_pd i=%0d got %b want %b", i, period_done, exp_pd); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL default_busy i=%0d got %b want 1", i, busy); end
      tick();
    end
  endtask

  task automatic test_burst();
    logic exp_clk, exp_pd;
    int   pd_cnt;
    do_reset();
    cfg_period = 8'd8; cfg_high = 8'd2; cfg_burst = 8'd3; cfg_valid = 1'b1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL burst_ready got %b want 1", cfg_ready); end
    tick(); cfg_valid = 1'b0;
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL burst_cfg_err got %b want 0", cfg_err); end
    start = 1'b1; tick(); start = 1'b0;
    pd_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      exp_clk = ((i % 8) < 2);
      exp_pd  = ((i % 8) == 7);
      if (period_done === 1'b1) pd_cnt++;
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL burst_clk i=%0d got %b want %b", i, clk_out, exp_clk); end
      n_cmp++; if (period_done !== exp_pd) begin n_bad++; $display("FAIL burst_pd i=%0d got %b want %b", i, period_done, exp_pd); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL burst_busy i=%0d got %b want 1", i, busy); end
      tick();
    end
    n_cmp++; if (pd_cnt != 3) begin n_bad++; $display("FAIL burst_pd_count got %0d want 3", pd_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL burst_end_busy i=%0d got %b want 0", i, busy); end
      n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL burst_end_clk i=%0d got %b want 0", i, clk_out); end
      n_cmp++; if (period_done !== 1'b0) begin n_bad++; $display("FAIL burst_end_pd i=%0d got %b want 0", i, period_done); end
      tick();
    end
  endtask

  task automatic test_shadow_update();
    logic exp_clk, exp_pd;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (clk_out !== 1'b1) begin n_bad++; $display("FAIL shadow_pre_clk c=%0d got %b want 1", c, clk_out); end
      tick();
    end
    cfg_period = 8'd4; cfg_high = 8'd1; cfg_burst = 8'd0; cfg_valid = 1'b1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL shadow_ready_c3 got %b want 1", cfg_ready); end
    tick(); cfg_valid = 1'b0;
    for (int c = 4; c < 10; c++) begin
      exp_clk = (c < 6);
      exp_pd  = (c == 9);
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL shadow_old_clk c=%0d got %b want %b", c, clk_out, exp_clk); end
      n_cmp++; if (period_done !== exp_pd) begin n_bad++; $display("FAIL shadow_old_pd c=%0d got %b want %b", c, period_done, exp_pd); end
      n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL shadow_ready_busy c=%0d got %b want 0", c, cfg_ready); end
      tick();
    end
    for (int j = 0; j < 12; j++) begin
      exp_clk = ((j % 4) == 0);
      exp_pd  = ((j % 4) == 3);
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL shadow_new_clk j=%0d got %b want %b", j, clk_out, exp_clk); end
      n_cmp++; if (period_done !== exp_pd) begin n_bad++; $display("FAIL shadow_new_pd j=%0d got %b want %b", j, period_done, exp_pd); end
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL shadow_ready_back j=%0d got %b want 1", j, cfg_ready); end
      tick();
    end
  endtask

  task automatic test_reject();
    logic exp_clk, exp_pd, exp_err;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    cfg_period = 8'd5; cfg_high = 8'd5; cfg_burst = 8'd0; cfg_valid = 1'b1;
    tick(); cfg_valid = 1'b0;
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL reject_high_eq_period got %b want 1", cfg_err); end
    tick();
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reject_err_one_cycle got %b want 0", cfg_err); end
    cfg_period = 8'd1; cfg_high = 8'd0; cfg_valid = 1'b1;
    tick(); cfg_valid = 1'b0;
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL reject_period_1 got %b want 1", cfg_err); end
    cfg_period = 8'd10; cfg_high = 8'd0; cfg_valid = 1'b1;
    tick(); cfg_valid = 1'b0;
    for (int c = 4; c < 24; c++) begin
      exp_clk = ((c % 10) < 6);
      exp_pd  = ((c % 10) == 9);
      exp_err = (c == 4);
      n_cmp++; if (cfg_err !== exp_err) begin n_bad++; $display("FAIL reject_err c=%0d got %b want %b", c, cfg_err, exp_err); end
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL reject_clk c=%0d got %b want %b", c, clk_out, exp_clk); end
      n_cmp++; if (period_done !== exp_pd) begin n_bad++; $display("FAIL reject_pd c=%0d got %b want %b", c, period_done, exp_pd); end
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reject_ready c=%0d got %b want 1", c, cfg_ready); end
      tick();
    end
  endtask

  task automatic test_stop_drain();
    logic exp_clk, exp_pd;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    for (int c = 3; c < 10; c++) begin
      exp_clk = (c < 6);
      exp_pd  = (c == 9);
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL drain_clk c=%0d got %b want %b", c, clk_out, exp_clk); end
      n_cmp++; if (period_done !== exp_pd) begin n_bad++; $display("FAIL drain_pd c=%0d got %b want %b", c, period_done, exp_pd); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy c=%0d got %b want 1", c, busy); end
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drain_idle_busy got %b want 0", busy); end
    n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL drain_idle_clk got %b want 0", clk_out); end
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_stop_busy i=%0d got %b want 0", i, busy); end
      n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL start_stop_clk i=%0d got %b want 0", i, clk_out); end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_rst_mid_run();
    logic exp_clk, exp_pd;
    do_reset();
    cfg_period = 8'd8; cfg_high = 8'd2; cfg_burst = 8'd0; cfg_valid = 1'b1;
    tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp_clk = (c < 2);
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL rstmid_pre_clk c=%0d got %b want %b", c, clk_out, exp_clk); end
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL rstmid_clk got %b want 0", clk_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got %b want 1", cfg_ready); end
    n_cmp++; if (period_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_pd got %b want 0", period_done); end
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      exp_clk = (c < 6);
      exp_pd  = (c == 9);
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL rstmid_def_clk c=%0d got %b want %b", c, clk_out, exp_clk); end
      n_cmp++; if (period_done !== exp_pd) begin n_bad++; $display("FAIL rstmid_def_pd c=%0d got %b want %b", c, period_done, exp_pd); end
      tick();
    end
  endtask

`ifdef CLK_GEN_CTRL_PCT_EN
  task automatic test_pct();
    logic exp_clk;
    do_reset();
    cfg_period = 8'd20; cfg_high = 8'd101; cfg_burst = 8'd0; cfg_valid = 1'b1;
    tick(); cfg_valid = 1'b0;
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL pct_reject_101 got %b want 1", cfg_err); end
    cfg_high = 8'd60; cfg_valid = 1'b1;
    tick(); cfg_valid = 1'b0;
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL pct_accept_err got %b want 0", cfg_err); end
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      exp_clk = (c < 12);
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL pct_clk c=%0d got %b want %b", c, clk_out, exp_clk); end
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_run();
    test_burst();
    test_shadow_update();
    test_reject();
    test_stop_drain();
    test_rst_mid_run();
`ifdef CLK_GEN_CTRL_PCT_EN
    test_pct();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
